run_control_unit: RTL and testbench

//  Run/step controller between the board clock and procesadorArm. It generates the

---
 rtl/run_control_unit.sv | 136 +++++++++++++
 tb/tb_run_control_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_control_unit.sv
// Run/step controller: generates the processor clock enable in free-run, debounced
// single-step, run-N and halt modes, with PC breakpoints and an enabled-cycle counter.
module run_control_unit #(
  parameter int PC_W     = 32,
  parameter int CNT_W    = 32,
  parameter int DEBOUNCE = 4,
  parameter int NUM_BP   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mode,
  input  logic                     step_btn,
  input  logic                     start,
  input  logic [CNT_W-1:0]         run_n,
  input  logic [PC_W-1:0]          pc,
  input  logic [NUM_BP*PC_W-1:0]   bp_addr,
  input  logic [NUM_BP-1:0]        bp_en,
  output logic                     cpu_en,
  output logic                     halted,
  output logic [NUM_BP-1:0]        bp_hit,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         remaining,
  output logic [1:0]               dbg_state
);

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_RUNN = 2'b10;
  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, STEP, RUNN} state_t;

  state_t            state;
  logic              resume;
  logic [1:0]        sync_q;
  logic              db_level;
  logic [DB_W-1:0]   db_cnt;
  logic              step_pulse;
  logic [NUM_BP-1:0] match_vec;
  logic              bp_match;
  logic              bp_stop;

  // Synchroniser plus debouncer; step_pulse is registered on the accepted rising level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      db_level   <= 1'b0;
      db_cnt     <= '0;
      step_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], step_btn};
      step_pulse <= 1'b0;
      if (sync_q[1] == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
        db_level   <= sync_q[1];
        db_cnt     <= '0;
        step_pulse <= sync_q[1];
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  always_comb begin
    match_vec = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      match_vec[i] = bp_en[i] && (pc == bp_addr[i*PC_W +: PC_W]);
    end
  end

  // The first cycle after leaving IDLE masks breakpoints so execution can step past one.
  assign bp_match  = |match_vec;
  assign bp_stop   = bp_match && !resume;
  assign cpu_en    = (state == STEP) || (((state == RUN) || (state == RUNN)) && !bp_stop);
  assign halted    = (state == IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      resume      <= 1'b0;
      bp_hit      <= '0;
      cycle_count <= '0;
      remaining   <= '0;
    end else begin
      resume <= 1'b0;
      if (cpu_en) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (mode == MODE_RUN) begin
            state  <= RUN;
            resume <= 1'b1;
            bp_hit <= '0;
          end else if ((mode == MODE_STEP) && step_pulse) begin
            state  <= STEP;
            resume <= 1'b1;
            bp_hit <= '0;
          end else if ((mode == MODE_RUNN) && start && (run_n != '0)) begin
            state     <= RUNN;
            resume    <= 1'b1;
            bp_hit    <= '0;
            remaining <= run_n;
          end
        end
        RUN: begin
          if (bp_stop) begin
            state  <= IDLE;
            bp_hit <= match_vec;
          end else if (mode != MODE_RUN) begin
            state <= IDLE;
          end
        end
        STEP: begin
          state <= IDLE;
        end
        RUNN: begin
          // A breakpoint wins over the last budgeted cycle: no decrement, no enable.
          if (bp_stop) begin
            state  <= IDLE;
            bp_hit <= match_vec;
          end else begin
            remaining <= remaining - CNT_W'(1);
            if ((mode != MODE_RUNN) || (remaining == CNT_W'(1))) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_control_unit.sv
// Bench for run_control_unit: directed scenarios plus randomized breakpoint and run-N
// runs checked against expectations computed from the enable/breakpoint rules.
module tb_run_control_unit;

  localparam int DEBOUNCE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        step_btn;
  logic        start;
  logic [31:0] run_n;
  logic [31:0] pc;
  logic [63:0] bp_addr;
  logic [1:0]  bp_en;

  logic        cpu_en, halted;
  logic [1:0]  bp_hit, dbg_state;
  logic [31:0] cycle_count, remaining;

  logic        cpu_en4, halted4;
  logic [1:0]  bp_hit4, dbg_state4;
  logic [3:0]  cycle_count4, remaining4;

  int n_checks = 0;
  int n_pass   = 0;

  run_control_unit #(.PC_W(32), .CNT_W(32), .DEBOUNCE(DEBOUNCE), .NUM_BP(2)) dut (
    .clk(clk), .rst(rst), .mode(mode), .step_btn(step_btn), .start(start),
    .run_n(run_n), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
    .cpu_en(cpu_en), .halted(halted), .bp_hit(bp_hit), .cycle_count(cycle_count),
    .remaining(remaining), .dbg_state(dbg_state)
  );

  run_control_unit #(.PC_W(32), .CNT_W(4), .DEBOUNCE(DEBOUNCE), .NUM_BP(2)) dut4 (
    .clk(clk), .rst(rst), .mode(mode), .step_btn(step_btn), .start(start),
    .run_n(run_n[3:0]), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
    .cpu_en(cpu_en4), .halted(halted4), .bp_hit(bp_hit4), .cycle_count(cycle_count4),
    .remaining(remaining4), .dbg_state(dbg_state4)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; leaves the bench at the negedge right after reset releases.
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; holds the button for 'hold' edges and watches 'window' cycles.
  task automatic press_step(input int hold, input int window,
                            output int n_en, output int first_idx);
    n_en = 0;
    first_idx = -1;
    step_btn = 1'b1;
    for (int i = 1; i <= window; i++) begin
      @(negedge clk);
      if (cpu_en) begin
        n_en++;
        if (first_idx < 0) first_idx = i;
      end
      if (i == hold) step_btn = 1'b0;
    end
  endtask

  // Called at a negedge after mode/start are set; the processor model advances pc by 4
  // after every enabled cycle. Returns at the negedge where halted is seen.
  task automatic run_with_pc(input int max_cycles, output int n_en, output bit timeout);
    bit en;
    n_en = 0;
    timeout = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (halted) begin
        timeout = 1'b0;
        break;
      end
      en = cpu_en;
      if (en) n_en++;
      @(posedge clk);
      #1 if (en) pc = pc + 32'd4;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    mode = 2'b00; step_btn = 1'b0; start = 1'b0; run_n = '0; pc = '0;
    bp_addr = '0; bp_en = 2'b00;
    @(negedge clk);
    do_reset();
    n_checks++; if (cpu_en !== 1'b0) $display("FAIL reset_cpu_en: got %b want 0", cpu_en); else n_pass++;
    n_checks++; if (halted !== 1'b1) $display("FAIL reset_halted: got %b want 1", halted); else n_pass++;
    n_checks++; if (cycle_count !== 32'd0 || remaining !== 32'd0 || bp_hit !== 2'b00)
      $display("FAIL reset_regs: cc=%0d rem=%0d bp_hit=%b want 0/0/00", cycle_count, remaining, bp_hit);
    else n_pass++;
  endtask

  task automatic test_free_run();
    int n_en = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cpu_en) n_en++;
    end
    mode = 2'b11;
    @(negedge clk);
    n_checks++; if (n_en != 10) $display("FAIL free_run_enables: got %0d want 10", n_en); else n_pass++;
    n_checks++; if (cycle_count !== 32'd10) $display("FAIL free_run_count: got %0d want 10", cycle_count); else n_pass++;
    n_checks++; if (halted !== 1'b1) $display("FAIL free_run_halt: got %b want 1", halted); else n_pass++;
  endtask

  task automatic test_step();
    int n_en = 0;
    int first_idx;
    logic [31:0] cc0;
    mode = 2'b01;
    repeat (3) @(negedge clk);
    cc0 = cycle_count;
    step_btn = 1'b1;
    repeat (2) @(negedge clk);
    step_btn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cpu_en) n_en++;
    end
    n_checks++; if (n_en != 0) $display("FAIL step_glitch: got %0d enables want 0", n_en); else n_pass++;
    press_step(20, 30, n_en, first_idx);
    n_checks++; if (n_en != 1) $display("FAIL step_count: got %0d enables want 1", n_en); else n_pass++;
    n_checks++; if (first_idx != 3 + DEBOUNCE)
      $display("FAIL step_latency: got cycle %0d want %0d", first_idx, 3 + DEBOUNCE);
    else n_pass++;
    n_checks++; if (cycle_count !== cc0 + 32'd1)
      $display("FAIL step_cycle_count: got %0d want %0d", cycle_count, cc0 + 32'd1);
    else n_pass++;
    mode = 2'b11;
  endtask

  task automatic test_run_n(input int n);
    int n_en;
    bit to;
    logic [31:0] cc0;
    bp_en = 2'b00;
    cc0 = cycle_count;
    mode = 2'b10; run_n = n; start = 1'b1;
    run_with_pc(n + 10, n_en, to);
    n_checks++; if (to || n_en != n) $display("FAIL run_n_enables: got %0d want %0d (timeout=%0b)", n_en, n, to); else n_pass++;
    n_checks++; if (remaining !== 32'd0 || halted !== 1'b1)
      $display("FAIL run_n_end: rem=%0d halted=%b want 0/1", remaining, halted);
    else n_pass++;
    n_checks++; if (cycle_count !== cc0 + n)
      $display("FAIL run_n_cycle_count: got %0d want %0d", cycle_count, cc0 + n);
    else n_pass++;
    mode = 2'b11;
  endtask

  task automatic test_breakpoint();
    int n_en;
    int first_idx;
    bit to;
    pc = 32'h0;
    bp_addr = {32'hFFFF_FFF0, 32'h0000_0040};
    bp_en = 2'b01;
    mode = 2'b00;
    run_with_pc(40, n_en, to);
    mode = 2'b01;
    n_checks++; if (to || n_en != 16) $display("FAIL bp_enables: got %0d want 16 (timeout=%0b)", n_en, to); else n_pass++;
    n_checks++; if (pc !== 32'h40) $display("FAIL bp_stop_pc: got %h want 00000040", pc); else n_pass++;
    n_checks++; if (bp_hit !== 2'b01 || halted !== 1'b1 || cpu_en !== 1'b0)
      $display("FAIL bp_hit: bp_hit=%b halted=%b cpu_en=%b want 01/1/0", bp_hit, halted, cpu_en);
    else n_pass++;
    press_step(10, 20, n_en, first_idx);
    n_checks++; if (n_en != 1) $display("FAIL bp_step_past: got %0d enables want 1", n_en); else n_pass++;
    n_checks++; if (bp_hit !== 2'b00) $display("FAIL bp_hit_clear: got %b want 00", bp_hit); else n_pass++;
    mode = 2'b11;
  endtask

  // Randomized breakpoint placement; odd iterations use run-N whose last budgeted
  // cycle lands exactly on the breakpoint, which must win.
  task automatic test_random_bp();
    int n_en;
    int target, slot, other;
    bit to;
    for (int it = 0; it < 6; it++) begin
      target = 4 * $urandom_range(1, 24);
      other  = target + 4 * $urandom_range(4, 8);
      slot   = $urandom_range(0, 1);
      pc = 32'h0;
      bp_addr = (slot == 0) ? {32'(other), 32'(target)} : {32'(target), 32'(other)};
      bp_en = 2'b11;
      @(negedge clk);
      if (it % 2 == 0) begin
        mode = 2'b00;
      end else begin
        mode = 2'b10; run_n = target / 4 + 1; start = 1'b1;
      end
      run_with_pc(200, n_en, to);
      mode = 2'b11;
      n_checks++; if (to || n_en != target / 4 || pc !== 32'(target))
        $display("FAIL rand_bp_stop it%0d: enables=%0d pc=%h want %0d/%h", it, n_en, pc, target / 4, target);
      else n_pass++;
      n_checks++; if (bp_hit !== 2'(1 << slot))
        $display("FAIL rand_bp_hit it%0d: got %b want %b", it, bp_hit, 2'(1 << slot));
      else n_pass++;
      if (it % 2 == 1) begin
        n_checks++; if (remaining !== 32'd1)
          $display("FAIL rand_bp_remaining it%0d: got %0d want 1", it, remaining);
        else n_pass++;
      end
      // Resume from the breakpoint: the first cycle must not re-trigger it.
      @(negedge clk);
      mode = 2'b10; run_n = 3; start = 1'b1;
      run_with_pc(20, n_en, to);
      mode = 2'b11;
      n_checks++; if (to || n_en != 3 || pc !== 32'(target + 12) || bp_hit !== 2'b00)
        $display("FAIL rand_bp_resume it%0d: enables=%0d pc=%h bp_hit=%b want 3/%h/00", it, n_en, pc, bp_hit, target + 12);
      else n_pass++;
    end
    bp_en = 2'b00;
  endtask

  task automatic test_zero_and_reset();
    int n_en = 0;
    bit found = 1'b0;
    @(negedge clk);
    mode = 2'b10; run_n = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cpu_en) n_en++;
    end
    n_checks++; if (n_en != 0 || halted !== 1'b1)
      $display("FAIL run_n_zero: enables=%0d halted=%b want 0/1", n_en, halted);
    else n_pass++;
    run_n = 8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (remaining == 32'd3) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++; if (!found) $display("FAIL reset_mid_run_wait: remaining=%0d never reached 3", remaining); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mode = 2'b11;
    n_checks++; if (remaining !== 32'd0 || cycle_count !== 32'd0 || halted !== 1'b1 || cpu_en !== 1'b0)
      $display("FAIL reset_mid_run: rem=%0d cc=%0d halted=%b cpu_en=%b want 0/0/1/0", remaining, cycle_count, halted, cpu_en);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int n_en = 0;
    int n_cycles;
    n_cycles = 17;
    pc = 32'h0;
    mode = 2'b00;
    do_reset();
    n_checks++; if (cycle_count4 !== 4'd0) $display("FAIL wrap_reset: got %0d want 0", cycle_count4); else n_pass++;
    for (int i = 0; i < n_cycles; i++) begin
      @(negedge clk);
      if (cpu_en4) n_en++;
    end
    mode = 2'b11;
    @(negedge clk);
    n_checks++; if (n_en != 17) $display("FAIL wrap_enables: got %0d want 17", n_en); else n_pass++;
    n_checks++; if (cycle_count4 !== 4'(n_cycles % 16))
      $display("FAIL wrap_count: got %0d want %0d", cycle_count4, n_cycles % 16);
    else n_pass++;
    n_checks++; if (cycle_count !== 32'(n_cycles))
      $display("FAIL wide_count: got %0d want %0d", cycle_count, n_cycles);
    else n_pass++;
  endtask

  // Sequence and final report
  initial begin
    rst = 1'b1;
    test_reset();
    test_free_run();
    test_step();
    test_run_n(5);
    test_run_n($urandom_range(1, 30));
    test_breakpoint();
    test_random_bp();
    test_zero_and_reset();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
